rdp_parity_accum: RTL and testbench

Downstream of the RDP systolic data cells: accumulates the per-beat `k1` and `k2` parity words into stripe parities P and Q by XOR over a programmable number of beats. Each finished stripe is presented on a valid/ready output and held until it is taken. Back-to-back stripes run without a bubble when the consumer is ready. Feeds the parity write-back path.

---
 rtl/rdp_pkg.sv | 20 ++
 rtl/rdp_xor_acc_lane.sv | 39 +++
 rtl/rdp_parity_accum.sv | 129 ++++++++++++
 tb/tb_rdp_parity_accum.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rdp_pkg.sv
// Shared types and helpers for the RDP parity accumulator.
package rdp_pkg;

    // Accumulating beats, or presenting a finished stripe.
    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } rdp_state_e;

    // Parity word width: all slices of one beat side by side.
    function automatic int word_w(input int slices, input int data_width);
        return slices * data_width;
    endfunction

    // A programmed length of zero behaves as a single-beat stripe.
    function automatic int unsigned norm_len(input int unsigned len);
        return (len == 0) ? 32'd1 : len;
    endfunction

endpackage

// File: rtl/rdp_xor_acc_lane.sv
// One W-bit XOR accumulator: load starts a new stripe, xor_en folds in a beat.
module rdp_xor_acc_lane
    import rdp_pkg::*;
#(
    parameter int W = 128
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic         xor_en,
    input  logic [W-1:0] din,
    output logic [W-1:0] acc
);

    logic [W-1:0] acc_d;
    logic [W-1:0] acc_q;

    // Load wins over xor so a new stripe never mixes with stale state.
    always_comb begin
        acc_d = acc_q;
        if (load) begin
            acc_d = din;
        end else if (xor_en) begin
            acc_d = acc_q ^ din;
        end
    end

    // Accumulator register, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/rdp_parity_accum.sv
// Accumulates k1/k2 parity beats into stripe P/Q and presents each stripe on valid/ready.
module rdp_parity_accum
    import rdp_pkg::*;
#(
    parameter int SLICES     = 4,
    parameter int DATA_WIDTH = 32,
    parameter int BEATS_W    = 8
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic [word_w(SLICES, DATA_WIDTH)-1:0]  t_k1_dat,
    input  logic [word_w(SLICES, DATA_WIDTH)-1:0]  t_k2_dat,
    input  logic                                   t_valid,
    input  logic                                   t_last,
    output logic                                   t_ready,
    input  logic [BEATS_W-1:0]                     cfg_len,
    output logic [word_w(SLICES, DATA_WIDTH)-1:0]  i_p_dat,
    output logic [word_w(SLICES, DATA_WIDTH)-1:0]  i_q_dat,
    output logic [BEATS_W-1:0]                     i_beats,
    output logic                                   i_short,
    output logic                                   i_valid,
    input  logic                                   i_ready
);

    localparam int W = word_w(SLICES, DATA_WIDTH);

    rdp_state_e         state_q, state_d;
    logic [BEATS_W-1:0] cnt_q, cnt_d;
    logic [BEATS_W-1:0] len_q, len_d;
    logic [W-1:0]       p_dat_q, p_dat_d;
    logic [W-1:0]       q_dat_q, q_dat_d;
    logic [BEATS_W-1:0] beats_q, beats_d;
    logic               short_q, short_d;

    logic               beat;
    logic               take;
    logic               first;
    logic               close;
    logic [BEATS_W-1:0] cur_len;
    logic [BEATS_W-1:0] cnt_new;
    logic [W-1:0]       acc_p;
    logic [W-1:0]       acc_q;
    logic [W-1:0]       p_fin;
    logic [W-1:0]       q_fin;

    // In HOLD the input is only accepted when the consumer frees the result slot.
    assign t_ready = (state_q == ACC) | i_ready;
    assign i_valid = (state_q == HOLD);
    assign beat    = t_valid & t_ready;
    assign take    = i_valid & i_ready;

    rdp_xor_acc_lane #(.W(W)) u_lane_p (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (first),
        .xor_en  (beat & ~first),
        .din     (t_k1_dat),
        .acc     (acc_p)
    );

    rdp_xor_acc_lane #(.W(W)) u_lane_q (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (first),
        .xor_en  (beat & ~first),
        .din     (t_k2_dat),
        .acc     (acc_q)
    );

    // Stripe bookkeeping: cnt is zero between stripes, so a zero count marks the first beat.
    always_comb begin
        first   = beat & (cnt_q == '0);
        cur_len = first ? BEATS_W'(norm_len(32'(cfg_len))) : len_q;
        cnt_new = first ? BEATS_W'(1) : cnt_q + BEATS_W'(1);
        close   = beat & ((cnt_new == cur_len) | t_last);
        p_fin   = first ? t_k1_dat : (acc_p ^ t_k1_dat);
        q_fin   = first ? t_k2_dat : (acc_q ^ t_k2_dat);

        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = first ? cur_len : len_q;
        p_dat_d = p_dat_q;
        q_dat_d = q_dat_q;
        beats_d = beats_q;
        short_d = short_q;

        if (take) begin
            state_d = ACC;
        end
        if (beat) begin
            cnt_d = cnt_new;
        end
        if (close) begin
            state_d = HOLD;
            cnt_d   = '0;
            p_dat_d = p_fin;
            q_dat_d = q_fin;
            beats_d = cnt_new;
            short_d = t_last & (cnt_new < cur_len);
        end
    end

    // FSM, counter, stripe length and registered result outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ACC;
            cnt_q   <= '0;
            len_q   <= BEATS_W'(1);
            p_dat_q <= '0;
            q_dat_q <= '0;
            beats_q <= '0;
            short_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            p_dat_q <= p_dat_d;
            q_dat_q <= q_dat_d;
            beats_q <= beats_d;
            short_q <= short_d;
        end
    end

    assign i_p_dat = p_dat_q;
    assign i_q_dat = q_dat_q;
    assign i_beats = beats_q;
    assign i_short = short_q;

endmodule

// File: tb/tb_rdp_parity_accum.sv
// Self-checking bench for rdp_parity_accum with a stripe-level reference model.
module tb_rdp_parity_accum;

    localparam int SLICES = 4;
    localparam int DW     = 32;
    localparam int BW     = 8;
    localparam int W      = SLICES * DW;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [W-1:0]  t_k1_dat, t_k2_dat;
    logic          t_valid, t_last, t_ready;
    logic [BW-1:0] cfg_len;
    logic [W-1:0]  i_p_dat, i_q_dat;
    logic [BW-1:0] i_beats;
    logic          i_short, i_valid, i_ready;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: beats of the open stripe and the pending result.
    logic [W-1:0]  m_k1[$];
    logic [W-1:0]  m_k2[$];
    int            m_len;
    logic          m_valid;
    logic [W-1:0]  m_p, m_q;
    int            m_beats;
    logic          m_short;
    logic          m_tready;
    logic          obs_tready;

    rdp_parity_accum #(.SLICES(SLICES), .DATA_WIDTH(DW), .BEATS_W(BW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .t_k1_dat (t_k1_dat),
        .t_k2_dat (t_k2_dat),
        .t_valid  (t_valid),
        .t_last   (t_last),
        .t_ready  (t_ready),
        .cfg_len  (cfg_len),
        .i_p_dat  (i_p_dat),
        .i_q_dat  (i_q_dat),
        .i_beats  (i_beats),
        .i_short  (i_short),
        .i_valid  (i_valid),
        .i_ready  (i_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout n_tests=%0d", n_tests);
        $fatal(1, "timeout");
    end

    function automatic logic [W-1:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_clear();
        m_k1.delete();
        m_k2.delete();
        m_len   = 1;
        m_valid = 1'b0;
        m_p     = '0;
        m_q     = '0;
        m_beats = 0;
        m_short = 1'b0;
    endtask

    // Drive one cycle from a negedge, advance the model at the posedge, return at the next negedge.
    task automatic step(input logic tv, input logic tl, input logic [W-1:0] k1,
                        input logic [W-1:0] k2, input logic ir, input logic [BW-1:0] cfg);
        logic beat_m;
        t_valid  = tv;
        t_last   = tl;
        t_k1_dat = k1;
        t_k2_dat = k2;
        i_ready  = ir;
        cfg_len  = cfg;
        m_tready = !m_valid || ir;
        #1 obs_tready = t_ready;
        @(posedge clk);
        beat_m = tv && m_tready;
        if (m_valid && ir) m_valid = 1'b0;
        if (beat_m) begin
            if (m_k1.size() == 0) m_len = (cfg == 0) ? 1 : int'(cfg);
            m_k1.push_back(k1);
            m_k2.push_back(k2);
            if (m_k1.size() == m_len || tl) begin
                m_p = '0;
                m_q = '0;
                foreach (m_k1[i]) begin
                    m_p = m_p ^ m_k1[i];
                    m_q = m_q ^ m_k2[i];
                end
                m_beats = m_k1.size();
                m_short = tl && (m_k1.size() < m_len);
                m_valid = 1'b1;
                m_k1.delete();
                m_k2.delete();
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic ir);
        step(1'b0, 1'b0, '0, '0, ir, cfg_len);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        model_clear();
        t_valid = 1'b0; t_last = 1'b0; t_k1_dat = '0; t_k2_dat = '0;
        i_ready = 1'b0; cfg_len = '0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({i_valid, i_short, i_beats, i_p_dat, i_q_dat} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got v=%0b s=%0b b=%0d p=%h q=%h required all zero",
                     i_valid, i_short, i_beats, i_p_dat, i_q_dat);
        end
        reset_n = 1'b1;
        #1;
        n_tests++;
        if (t_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_tready got %0b required 1", t_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [W-1:0] ff_w;
        ff_w = {SLICES{32'hFF}};
        for (int b = 0; b < 4; b++) begin
            step(1'b1, 1'b0, {SLICES{32'(1) << b}}, ff_w, 1'b1, 8'd4);
            n_tests++;
            if (i_valid !== (b == 3)) begin
                n_fail++;
                $display("FAIL basic_valid_beat%0d got %0b required %0b", b + 1, i_valid, b == 3);
            end
        end
        n_tests++;
        if (i_p_dat !== {SLICES{32'hF}} || i_q_dat !== '0 || i_beats !== 8'd4 || i_short !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_result got p=%h q=%h b=%0d s=%0b required p=%h q=0 b=4 s=0",
                     i_p_dat, i_q_dat, i_beats, i_short, {SLICES{32'hF}});
        end
        idle(1'b1);
        n_tests++;
        if (i_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_taken got valid=%0b required 0", i_valid);
        end
    endtask

    task automatic test_short();
        for (int b = 0; b < 3; b++) step(1'b1, b == 2, rnd_word(), rnd_word(), 1'b1, 8'd8);
        n_tests++;
        if (i_valid !== 1'b1 || i_beats !== 8'd3 || i_short !== 1'b1 || i_p_dat !== m_p || i_q_dat !== m_q) begin
            n_fail++;
            $display("FAIL short_early got v=%0b b=%0d s=%0b p=%h required v=1 b=3 s=1 p=%h",
                     i_valid, i_beats, i_short, i_p_dat, m_p);
        end
        idle(1'b1);
        for (int b = 0; b < 3; b++) step(1'b1, b == 2, rnd_word(), rnd_word(), 1'b1, 8'd3);
        n_tests++;
        if (i_valid !== 1'b1 || i_beats !== 8'd3 || i_short !== 1'b0 || i_q_dat !== m_q) begin
            n_fail++;
            $display("FAIL short_exact got v=%0b b=%0d s=%0b q=%h required v=1 b=3 s=0 q=%h",
                     i_valid, i_beats, i_short, i_q_dat, m_q);
        end
        idle(1'b1);
    endtask

    task automatic test_single();
        logic [W-1:0] a, b;
        for (int n = 0; n < 10; n++) begin
            a = rnd_word();
            b = rnd_word();
            step(1'b1, 1'b0, a, b, 1'b1, (n < 5) ? 8'd0 : 8'd1);
            n_tests++;
            if (obs_tready !== 1'b1 || i_valid !== 1'b1 || i_p_dat !== a || i_q_dat !== b || i_beats !== 8'd1) begin
                n_fail++;
                $display("FAIL single_%0d got tr=%0b v=%0b p=%h q=%h b=%0d required tr=1 v=1 p=%h q=%h b=1",
                         n, obs_tready, i_valid, i_p_dat, i_q_dat, i_beats, a, b);
            end
        end
        idle(1'b1);
    endtask

    task automatic test_backpressure();
        logic [W-1:0] sp, sq, a, b;
        step(1'b1, 1'b0, rnd_word(), rnd_word(), 1'b0, 8'd2);
        step(1'b1, 1'b0, rnd_word(), rnd_word(), 1'b0, 8'd2);
        sp = i_p_dat;
        sq = i_q_dat;
        n_tests++;
        if (i_valid !== 1'b1 || sp !== m_p || sq !== m_q) begin
            n_fail++;
            $display("FAIL bp_close got v=%0b p=%h required v=1 p=%h", i_valid, sp, m_p);
        end
        for (int n = 0; n < 10; n++) begin
            step(1'b1, 1'b0, rnd_word(), rnd_word(), 1'b0, 8'd2);
            n_tests++;
            if (obs_tready !== 1'b0 || i_valid !== 1'b1 || i_p_dat !== sp || i_q_dat !== sq || i_beats !== 8'd2) begin
                n_fail++;
                $display("FAIL bp_hold_%0d got tr=%0b v=%0b p=%h b=%0d required tr=0 v=1 p=%h b=2",
                         n, obs_tready, i_valid, i_p_dat, i_beats, sp);
            end
        end
        a = rnd_word();
        b = rnd_word();
        step(1'b1, 1'b0, a, rnd_word(), 1'b1, 8'd2);
        n_tests++;
        if (obs_tready !== 1'b1 || i_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release got tr=%0b v=%0b required tr=1 v=0", obs_tready, i_valid);
        end
        step(1'b1, 1'b0, b, rnd_word(), 1'b1, 8'd2);
        n_tests++;
        if (i_valid !== 1'b1 || i_p_dat !== (a ^ b) || i_q_dat !== m_q) begin
            n_fail++;
            $display("FAIL bp_fresh got v=%0b p=%h required v=1 p=%h", i_valid, i_p_dat, a ^ b);
        end
        idle(1'b1);
    endtask

    task automatic test_cfg_change();
        step(1'b1, 1'b0, rnd_word(), rnd_word(), 1'b1, 8'd2);
        step(1'b1, 1'b0, rnd_word(), rnd_word(), 1'b1, 8'd6);
        n_tests++;
        if (i_valid !== 1'b1 || i_beats !== 8'd2 || i_p_dat !== m_p) begin
            n_fail++;
            $display("FAIL cfg_close2 got v=%0b b=%0d required v=1 b=2", i_valid, i_beats);
        end
        for (int n = 0; n < 6; n++) begin
            step(1'b1, 1'b0, rnd_word(), rnd_word(), 1'b1, (n == 0) ? 8'd6 : 8'd1);
            n_tests++;
            if (i_valid !== (n == 5)) begin
                n_fail++;
                $display("FAIL cfg_len6_beat%0d got v=%0b required %0b", n + 1, i_valid, n == 5);
            end
        end
        n_tests++;
        if (i_beats !== 8'd6 || i_p_dat !== m_p || i_q_dat !== m_q) begin
            n_fail++;
            $display("FAIL cfg_len6_result got b=%0d p=%h required b=6 p=%h", i_beats, i_p_dat, m_p);
        end
        idle(1'b1);
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] xp;
        step(1'b1, 1'b0, rnd_word(), rnd_word(), 1'b1, 8'd4);
        step(1'b1, 1'b0, rnd_word(), rnd_word(), 1'b1, 8'd4);
        #2 reset_n = 1'b0;
        model_clear();
        #1;
        n_tests++;
        if ({i_valid, i_short, i_beats, i_p_dat, i_q_dat} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_outputs got v=%0b b=%0d p=%h q=%h required all zero",
                     i_valid, i_beats, i_p_dat, i_q_dat);
        end
        @(negedge clk);
        reset_n = 1'b1;
        xp = '0;
        for (int n = 0; n < 4; n++) begin
            t_k1_dat = rnd_word();
            xp = xp ^ t_k1_dat;
            step(1'b1, 1'b0, t_k1_dat, rnd_word(), 1'b1, 8'd4);
        end
        n_tests++;
        if (i_valid !== 1'b1 || i_p_dat !== xp || i_q_dat !== m_q || i_beats !== 8'd4) begin
            n_fail++;
            $display("FAIL rstmid_result got v=%0b p=%h b=%0d required v=1 p=%h b=4",
                     i_valid, i_p_dat, i_beats, xp);
        end
        idle(1'b1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, rnd_word(), rnd_word(),
                 $urandom_range(0, 9) < 7, BW'($urandom_range(0, 5)));
            n_tests++;
            if (obs_tready !== m_tready || i_valid !== m_valid) begin
                n_fail++;
                $display("FAIL rand_handshake_%0d got tr=%0b v=%0b required tr=%0b v=%0b",
                         n, obs_tready, i_valid, m_tready, m_valid);
            end
            if (m_valid) begin
                n_tests++;
                if (i_p_dat !== m_p || i_q_dat !== m_q || i_beats !== BW'(m_beats) || i_short !== m_short) begin
                    n_fail++;
                    $display("FAIL rand_result_%0d got p=%h q=%h b=%0d s=%0b required p=%h q=%h b=%0d s=%0b",
                             n, i_p_dat, i_q_dat, i_beats, i_short, m_p, m_q, m_beats, m_short);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short();
        test_single();
        test_backpressure();
        test_cfg_change();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
